regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised general/float register file with an integrated per-register pending-write scoreboard. Replaces the fixed 64-entry, enable-per-register file.
- Supports N combinational read ports and one commit write port, with optional write-to-read bypass and an optional hardwired zero register.
- Tracks outstanding writes per register so the issue stage can detect RAW hazards directly from the file.

Parameters:
- WIDTH, 32, data bits per register.
- NUM, 64, number of registers (r0-r31 integer, r32-r63 float at default).
- NRD, 3, number of read ports.
- PEND_W, 2, width of the per-register pending counter; max outstanding writes is 2^PEND_W-1.
- ZERO_REG, 1, when 1 register 0 is hardwired to zero and never busy.
- FWD, 1, when 1 a same-cycle commit write is bypassed to the read ports.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rstn  in  1  asynchronous active-low reset.
- rd_addr  in  NRD*AW  read addresses, port k at [k*AW +: AW], AW = clog2(NUM).
- rd_data  out  NRD*WIDTH  read data, port k at [k*WIDTH +: WIDTH].
- rd_busy  out  NRD  port k's register has outstanding writes (after same-cycle effects, see below).
- rsv_en  in  1  issue stage reserves one pending write to rsv_addr.
- rsv_addr  in  AW  destination being reserved.
- rsv_ok  out  1  reservation accepted this cycle (combinational).
- wr_en  in  1  commit write.
- wr_addr  in  AW  commit destination.
- wr_data  in  WIDTH  commit data.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (rstn low, asynchronous): all registers 0, all pending counters 0, err 0. Outputs are then rd_data = 0, rd_busy = 0, rsv_ok = rsv_en. Reset mid-operation discards every reservation.
- Read path is combinational:
  - rd_data = reg[rd_addr].
  - If FWD=1 and wr_en and wr_addr == rd_addr and the address is not a hardwired zero, rd_data = wr_data instead.
  - Address >= NUM reads 0 and is never busy.
- Write: on a clock edge with wr_en, reg[wr_addr] <= wr_data. Ignored when ZERO_REG=1 and wr_addr=0, or when wr_addr >= NUM.
- Pending counter cnt[i], per register:
  - rsv accepted only: +1.
  - commit only: -1.
  - both to the same register in the same cycle: unchanged.
- rsv_ok:
  - rsv_en and cnt[rsv_addr] < 2^PEND_W-1.
  - Also true when the counter is saturated but a same-cycle commit decrements that register.
  - When ZERO_REG=1 and rsv_addr=0: rsv_ok=1 and no count change.
- rd_busy[k] = (cnt[rd_addr] - commit_hit) != 0.
  - commit_hit = wr_en and wr_addr == rd_addr.
  - A same-cycle reservation does NOT raise busy until the next cycle.
  - With FWD=0, commit_hit is forced 0 for busy, so the register stays busy in the commit cycle.
- err is set and stays set until reset when either occurs:
  - wr_en to a register with cnt = 0, unless it is the zero register or a same-cycle reservation targets it (the count is left unchanged).
  - rsv_en rejected (rsv_ok = 0).
- Zero register, or ZERO_REG=0: reg 0 behaves as an ordinary register.
- Pending counters never wrap: increment only while below max, decrement only while above 0.

Decomposition:
- Shared package/header `common.h` holds:
  - default WIDTH, NUM, NRD, PEND_W;
  - an AW macro (clog2 of NUM);
  - the register-index constants (ZERO_IDX = 0, FLOAT_BASE = 32).
- One natural sub-module, regfile_sb_cell. It holds one register plus its pending counter. Inputs are per-cell wr_hit, rsv_hit, wr_data. Outputs are value, cnt_nz and cnt_sat. It is instantiated NUM times with a generate loop.
- Read muxes, bypass, rsv_ok and err logic stay in the top.

Test Plan:
- Reset, then read ports 0..2 at addrs 1, 32, 63 -> rd_data 0, rd_busy 000, err 0. Pulse rstn low mid-sequence with cnt[5]=2 -> cnt[5] cleared immediately, rd_busy drops asynchronously.
- rsv r5 in cycle 0, read r5 in cycle 1 -> busy=1. Commit r5=0xDEADBEEF in cycle 3 while reading r5 -> rd_data 0xDEADBEEF (bypass), busy=0 in the same cycle. Cycle 4 -> reg holds the value, busy 0.
- Reserve r7 three times (PEND_W=2) -> rsv_ok 1,1,1. Fourth reserve -> rsv_ok 0, err=1. Fourth reserve with a same-cycle commit to r7 -> rsv_ok 1, cnt stays 3.
- Simultaneous rsv and commit to r9 with cnt=1 -> cnt stays 1, rd_busy 1 next cycle, reg[9] updated, err 0.
- Write r0=0x1234 and rsv r0 with ZERO_REG=1 -> reads 0, never busy, err 0. Rerun with ZERO_REG=0 -> reads 0x1234.
- Commit to r12 with cnt=0 and no reservation -> data written, err rises next edge and holds until rstn low. With FWD=0, commit r3 while reading r3 -> old value and busy=1 that cycle, new value the next cycle.

Source files
------------

// File: rtl/regfile_sb_pkg.sv
// ---------------------------------------------------------------------------
// regfile_sb_pkg
// Shared constants for the scoreboarded register file: default geometry,
// address width helper and the architectural register-index landmarks.
// No ports; imported by regfile_sb and regfile_sb_cell.
// ---------------------------------------------------------------------------
package regfile_sb_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_NUM    = 64;
    localparam int DEF_NRD    = 3;
    localparam int DEF_PEND_W = 2;
    localparam int DEF_AW     = $clog2(DEF_NUM);

    // r0 is the (optionally hardwired) zero register; float registers start at r32
    localparam int ZERO_IDX   = 0;
    localparam int FLOAT_BASE = 32;

    typedef enum logic [0:0] {
        BANK_INT   = 1'b0,
        BANK_FLOAT = 1'b1
    } reg_bank_e;

    // Which architectural bank a register index belongs to
    function automatic reg_bank_e bankOf(input int idx);
        return (idx >= FLOAT_BASE) ? BANK_FLOAT : BANK_INT;
    endfunction

endpackage

// File: rtl/regfile_sb_cell.sv
// ---------------------------------------------------------------------------
// regfile_sb_cell
// One architectural register plus its pending-write counter.
// Ports:
//   clk, rstn      clock / asynchronous active-low reset
//   wr_hit_i       commit write lands in this register this cycle
//   rsv_hit_i      an accepted reservation targets this register this cycle
//   wr_data_i      commit data
//   value_o        current register contents
//   cnt_nz_o       at least one write outstanding
//   cnt_sat_o      counter at its maximum (no more reservations fit)
//   cnt_multi_o    two or more writes outstanding (still busy after a commit)
// ---------------------------------------------------------------------------
module regfile_sb_cell
    import regfile_sb_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int PEND_W = DEF_PEND_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_hit_i,
    input  logic             rsv_hit_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic [WIDTH-1:0] value_o,
    output logic             cnt_nz_o,
    output logic             cnt_sat_o,
    output logic             cnt_multi_o
);

    localparam logic [PEND_W-1:0] CNT_MAX = '1;
    localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

    logic [WIDTH-1:0]  value_q;
    logic [PEND_W-1:0] cnt_q;
    logic [PEND_W-1:0] cnt_d;

    // A reservation and a commit in the same cycle cancel out; otherwise the
    // counter moves by one but never wraps past either end.
    always_comb begin
        cnt_d = cnt_q;
        if (rsv_hit_i && !wr_hit_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end else if (wr_hit_i && !rsv_hit_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            value_q <= '0;
            cnt_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (wr_hit_i) begin
                value_q <= wr_data_i;
            end
        end
    end

    assign value_o     = value_q;
    assign cnt_nz_o    = (cnt_q != '0);
    assign cnt_sat_o   = (cnt_q == CNT_MAX);
    assign cnt_multi_o = (cnt_q > CNT_ONE);

endmodule

// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb
// Parametrised integer/float register file with a per-register pending-write
// scoreboard so the issue stage can see RAW hazards straight from the file.
// Ports:
//   clk, rstn   clock / asynchronous active-low reset
//   rd_addr     NRD packed read addresses, port k at [k*AW +: AW]
//   rd_data     NRD packed read data, port k at [k*WIDTH +: WIDTH]
//   rd_busy     per-port: addressed register still has outstanding writes
//   rsv_en/_addr/rsv_ok   reserve one pending write, accepted flag
//   wr_en/_addr/_data     commit write port
//   err         sticky protocol error (orphan commit or rejected reservation)
// ---------------------------------------------------------------------------
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NUM      = DEF_NUM,
    parameter int NRD      = DEF_NRD,
    parameter int PEND_W   = DEF_PEND_W,
    parameter int ZERO_REG = 1,
    parameter int FWD      = 1,
    localparam int AW      = $clog2(NUM)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NRD*AW-1:0]  rd_addr,
    output logic [NRD*WIDTH-1:0] rd_data,
    output logic [NRD-1:0]     rd_busy,
    input  logic               rsv_en,
    input  logic [AW-1:0]      rsv_addr,
    output logic               rsv_ok,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [WIDTH-1:0]   wr_data,
    output logic               err
);

    function automatic logic isHardZero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == AW'(ZERO_IDX));
    endfunction

    function automatic logic inRange(input logic [AW-1:0] a);
        return int'(a) < NUM;
    endfunction

    logic [WIDTH-1:0] cellVal [NUM];
    logic [NUM-1:0]   cellNz;
    logic [NUM-1:0]   cellSat;
    logic [NUM-1:0]   cellMulti;

    logic wrValid;
    logic rsvTracked;
    logic rsvSat;
    logic rsvCommit;
    logic rsvAccept;
    logic wrOrphan;
    logic err_q;
    logic err_d;

    // Commits to the hardwired zero register or past the end are dropped
    assign wrValid = wr_en && inRange(wr_addr) && !isHardZero(wr_addr);

    // A saturated counter can still take a reservation when the same cycle's
    // commit frees one slot; reservations of the zero register are accepted
    // but never counted.
    assign rsvTracked = inRange(rsv_addr) && !isHardZero(rsv_addr);
    assign rsvSat     = rsvTracked && cellSat[rsv_addr];
    assign rsvCommit  = wrValid && (wr_addr == rsv_addr);
    assign rsv_ok     = rsv_en && (!rsvSat || rsvCommit);
    assign rsvAccept  = rsv_ok && rsvTracked;

    generate
        for (genvar i = 0; i < NUM; i++) begin : g_cell
            regfile_sb_cell #(
                .WIDTH (WIDTH),
                .PEND_W(PEND_W)
            ) u_cell (
                .clk        (clk),
                .rstn       (rstn),
                .wr_hit_i   (wrValid && (wr_addr == AW'(i))),
                .rsv_hit_i  (rsvAccept && (rsv_addr == AW'(i))),
                .wr_data_i  (wr_data),
                .value_o    (cellVal[i]),
                .cnt_nz_o   (cellNz[i]),
                .cnt_sat_o  (cellSat[i]),
                .cnt_multi_o(cellMulti[i])
            );
        end
    endgenerate

    // Read ports: optional same-cycle bypass of the commit data. A commit to the
    // read register retires one pending write for busy purposes (only with the
    // bypass enabled), so busy then needs a second outstanding write. An orphan
    // commit (count already 0) does not make the register look busy.
    generate
        for (genvar k = 0; k < NRD; k++) begin : g_rd
            logic [AW-1:0] rdA;
            logic          rdIn;
            logic          fwdHit;
            logic          busyHit;

            assign rdA     = rd_addr[k*AW +: AW];
            assign rdIn    = inRange(rdA);
            assign fwdHit  = (FWD != 0) && wr_en && (wr_addr == rdA) && !isHardZero(rdA);
            assign busyHit = (FWD != 0) && wr_en && (wr_addr == rdA);

            assign rd_data[k*WIDTH +: WIDTH] = !rdIn  ? '0 :
                                               fwdHit ? wr_data : cellVal[rdA];
            assign rd_busy[k] = rdIn && !isHardZero(rdA) &&
                                (busyHit ? cellMulti[rdA] : cellNz[rdA]);
        end
    endgenerate

    // A commit with nothing outstanding is a protocol error unless a reservation
    // to the same register arrives in the same cycle.
    assign wrOrphan = wrValid && !cellNz[wr_addr] && !(rsv_en && (rsv_addr == wr_addr));
    assign err_d    = err_q || wrOrphan || (rsv_en && !rsv_ok);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_regfile_sb.sv
// ---------------------------------------------------------------------------
// tb_regfile_sb
// Drives two register files from the same stimulus: one with the default
// configuration (hardwired r0, write bypass) and one with both disabled.
// A behavioural scoreboard model predicts every output each cycle; directed
// sequences add literal expectations on top.
// ---------------------------------------------------------------------------
module tb_regfile_sb;

    localparam int W    = 32;
    localparam int N    = 64;
    localparam int NR   = 3;
    localparam int A    = 6;
    localparam int MAXC = 3;

    logic            clk;
    logic            rstn;
    logic [NR*A-1:0] rd_addr;
    logic            rsv_en;
    logic [A-1:0]    rsv_addr;
    logic            wr_en;
    logic [A-1:0]    wr_addr;
    logic [W-1:0]    wr_data;

    logic [NR*W-1:0] dataA, dataB;
    logic [NR-1:0]   busyA, busyB;
    logic            rsvOkA, rsvOkB;
    logic            errA, errB;

    int checks = 0;
    int errors = 0;

    regfile_sb dutA (
        .clk(clk), .rstn(rstn), .rd_addr(rd_addr), .rd_data(dataA), .rd_busy(busyA),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsvOkA),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .err(errA)
    );

    regfile_sb #(.ZERO_REG(0), .FWD(0)) dutB (
        .clk(clk), .rstn(rstn), .rd_addr(rd_addr), .rd_data(dataB), .rd_busy(busyB),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsvOkB),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .err(errB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: index 0 mirrors dutA (zero reg + bypass), 1 mirrors dutB
    int       cntM [2][N];
    bit [W-1:0] regM [2][N];
    bit       errM [2];

    function automatic bit cfgZero(input int c);
        return c == 0;
    endfunction

    function automatic bit cfgFwd(input int c);
        return c == 0;
    endfunction

    function automatic bit isZero(input int c, input int a);
        return cfgZero(c) && (a == 0);
    endfunction

    function automatic bit expRsvOk(input int c);
        if (!rsv_en) return 1'b0;
        if (isZero(c, int'(rsv_addr))) return 1'b1;
        if (cntM[c][rsv_addr] < MAXC) return 1'b1;
        return wr_en && (wr_addr == rsv_addr);
    endfunction

    function automatic bit [W-1:0] expData(input int c, input int a);
        if (cfgFwd(c) && wr_en && (int'(wr_addr) == a) && !isZero(c, a)) return wr_data;
        return regM[c][a];
    endfunction

    function automatic bit expBusy(input int c, input int a);
        int hit;
        if (isZero(c, a)) return 1'b0;
        hit = (cfgFwd(c) && wr_en && (int'(wr_addr) == a)) ? 1 : 0;
        return (cntM[c][a] - hit) > 0;
    endfunction

    function automatic int portAddr(input int k);
        return int'(rd_addr[k*A +: A]);
    endfunction

    function automatic logic [W-1:0] port0(input logic [NR*W-1:0] v);
        return v[W-1:0];
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int c = 0; c < 2; c++) begin
                errM[c] = 1'b0;
                for (int i = 0; i < N; i++) begin
                    cntM[c][i] = 0;
                    regM[c][i] = '0;
                end
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                bit ok, rsvAcc, wrV, orphan;
                int ra, wa;
                ra     = int'(rsv_addr);
                wa     = int'(wr_addr);
                ok     = expRsvOk(c);
                rsvAcc = ok && !isZero(c, ra);
                wrV    = wr_en && !isZero(c, wa);
                orphan = wrV && (cntM[c][wa] == 0) && !(rsv_en && ra == wa);
                if (orphan || (rsv_en && !ok)) errM[c] = 1'b1;
                if (!(rsvAcc && wrV && ra == wa)) begin
                    if (rsvAcc) cntM[c][ra] = (cntM[c][ra] + 1 > MAXC) ? MAXC : cntM[c][ra] + 1;
                    if (wrV)    cntM[c][wa] = (cntM[c][wa] - 1 < 0) ? 0 : cntM[c][wa] - 1;
                end
                if (wrV) regM[c][wa] = wr_data;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [NR*W-1:0] act,
                               input logic [NR*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both DUTs against the model
    always @(negedge clk) begin : compare
        logic [NR*W-1:0] eDataA, eDataB;
        logic [NR-1:0]   eBusyA, eBusyB;
        for (int k = 0; k < NR; k++) begin
            eDataA[k*W +: W] = expData(0, portAddr(k));
            eDataB[k*W +: W] = expData(1, portAddr(k));
            eBusyA[k]        = expBusy(0, portAddr(k));
            eBusyB[k]        = expBusy(1, portAddr(k));
        end
        checkOutput("model A rd_data", dataA, eDataA);
        checkOutput("model A rd_busy", busyA, eBusyA);
        checkOutput("model A rsv_ok",  rsvOkA, expRsvOk(0));
        checkOutput("model A err",     errA, errM[0]);
        checkOutput("model B rd_data", dataB, eDataB);
        checkOutput("model B rd_busy", busyB, eBusyB);
        checkOutput("model B rsv_ok",  rsvOkB, expRsvOk(1));
        checkOutput("model B err",     errB, errM[1]);
    end

    // Drives one cycle of inputs just after the rising edge, returns at the
    // following falling edge so callers can check the combinational outputs.
    task automatic applyStimulus(input bit rEn, input int rA, input bit wEn, input int wA,
                                 input bit [W-1:0] wD, input int rdA);
        @(posedge clk);
        #1;
        rsv_en   = rEn;
        rsv_addr = A'(rA);
        wr_en    = wEn;
        wr_addr  = A'(wA);
        wr_data  = wD;
        rd_addr  = {A'(rdA), A'(rdA), A'(rdA)};
        @(negedge clk);
    endtask

    task automatic pulseReset();
        #2 rstn = 1'b0;
        #5 rstn = 1'b1;
    endtask

    initial begin
        rstn     = 1'b1;
        rsv_en   = 1'b1;
        rsv_addr = 6'd5;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rd_addr  = {6'd63, 6'd32, 6'd1};
        #1 rstn = 1'b0;
        #2;
        checkOutput("reset rd_data", dataA, '0);
        checkOutput("reset rd_busy", busyA, 3'b000);
        checkOutput("reset err",     errA, 1'b0);
        checkOutput("reset rsv_ok follows rsv_en", rsvOkA, 1'b1);
        repeat (2) @(negedge clk);
        #2;
        rstn   = 1'b1;
        rsv_en = 1'b0;

        // Idle reads of r1/r32/r63 after reset
        @(posedge clk);
        @(negedge clk);
        checkOutput("post-reset rd_data", dataA, '0);
        checkOutput("post-reset rd_busy", busyA, 3'b000);
        checkOutput("post-reset err",     errA, 1'b0);

        // Reserve r5, then commit with bypass
        applyStimulus(1, 5, 0, 0, 0, 5);
        checkOutput("r5 rsv_ok", rsvOkA, 1'b1);
        checkOutput("r5 busy same cycle as rsv", busyA, 3'b000);
        applyStimulus(0, 0, 0, 0, 0, 5);
        checkOutput("r5 busy after rsv", busyA, 3'b111);
        applyStimulus(0, 0, 0, 0, 0, 5);
        applyStimulus(0, 0, 1, 5, 32'hDEADBEEF, 5);
        checkOutput("r5 bypass data A", port0(dataA), 32'hDEADBEEF);
        checkOutput("r5 busy commit cycle A", busyA, 3'b000);
        checkOutput("r5 no bypass data B", port0(dataB), 32'h0);
        checkOutput("r5 busy commit cycle B", busyB, 3'b111);
        applyStimulus(0, 0, 0, 0, 0, 5);
        checkOutput("r5 stored A", port0(dataA), 32'hDEADBEEF);
        checkOutput("r5 stored B", port0(dataB), 32'hDEADBEEF);
        checkOutput("r5 busy after commit", busyA, 3'b000);
        checkOutput("r5 err", errA, 1'b0);

        // Saturate r7
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 7, 0, 0, 0, 7);
            checkOutput("r7 rsv accepted", rsvOkA, 1'b1);
        end
        applyStimulus(1, 7, 0, 0, 0, 7);
        checkOutput("r7 4th rsv rejected", rsvOkA, 1'b0);
        applyStimulus(1, 7, 1, 7, 32'h77, 7);
        checkOutput("r7 err after reject", errA, 1'b1);
        checkOutput("r7 rsv with commit", rsvOkA, 1'b1);
        checkOutput("r7 bypass", port0(dataA), 32'h77);
        applyStimulus(0, 0, 0, 0, 0, 7);
        checkOutput("r7 still busy", busyA, 3'b111);

        // r5 with two pending, then asynchronous reset
        applyStimulus(1, 5, 0, 0, 0, 5);
        applyStimulus(1, 5, 0, 0, 0, 5);
        applyStimulus(0, 0, 0, 0, 0, 5);
        checkOutput("r5 busy before reset", busyA, 3'b111);
        #2 rstn = 1'b0;
        #1;
        checkOutput("async reset busy A", busyA, 3'b000);
        checkOutput("async reset busy B", busyB, 3'b000);
        checkOutput("async reset err", errA, 1'b0);
        #4 rstn = 1'b1;

        // Simultaneous reserve and commit on r9
        applyStimulus(1, 9, 0, 0, 0, 9);
        applyStimulus(1, 9, 1, 9, 32'h99, 9);
        checkOutput("r9 rsv_ok", rsvOkA, 1'b1);
        applyStimulus(0, 0, 0, 0, 0, 9);
        checkOutput("r9 busy A", busyA, 3'b111);
        checkOutput("r9 data A", port0(dataA), 32'h99);
        checkOutput("r9 busy B", busyB, 3'b111);
        checkOutput("r9 err A", errA, 1'b0);

        // Zero register
        applyStimulus(1, 0, 1, 0, 32'h1234, 0);
        checkOutput("r0 rsv_ok A", rsvOkA, 1'b1);
        checkOutput("r0 rsv_ok B", rsvOkB, 1'b1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("r0 hardwired", port0(dataA), 32'h0);
        checkOutput("r0 busy A", busyA, 3'b000);
        checkOutput("r0 ordinary B", port0(dataB), 32'h1234);
        checkOutput("r0 busy B", busyB, 3'b000);
        checkOutput("r0 err A", errA, 1'b0);
        checkOutput("r0 err B", errB, 1'b0);

        // No bypass on B for r3
        applyStimulus(1, 3, 0, 0, 0, 3);
        applyStimulus(0, 0, 1, 3, 32'h33, 3);
        checkOutput("r3 old value B", port0(dataB), 32'h0);
        checkOutput("r3 busy B", busyB, 3'b111);
        checkOutput("r3 bypass A", port0(dataA), 32'h33);
        applyStimulus(0, 0, 0, 0, 0, 3);
        checkOutput("r3 new value B", port0(dataB), 32'h33);
        checkOutput("r3 idle B", busyB, 3'b000);

        // Orphan commit to r12
        applyStimulus(0, 0, 1, 12, 32'hC0DE, 12);
        checkOutput("r12 err same cycle", errA, 1'b0);
        applyStimulus(0, 0, 0, 0, 0, 12);
        checkOutput("r12 err A", errA, 1'b1);
        checkOutput("r12 err B", errB, 1'b1);
        checkOutput("r12 data", port0(dataA), 32'hC0DE);
        applyStimulus(0, 0, 0, 0, 0, 12);
        checkOutput("r12 err sticky", errA, 1'b1);
        pulseReset();

        // Randomised traffic over a narrow address window to force collisions
        for (int cyc = 0; cyc < 2000; cyc++) begin
            int rA, wA;
            rA = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N-1)) : int'($urandom_range(0, 7));
            wA = ($urandom_range(0, 3) == 0) ? rA : int'($urandom_range(0, 7));
            @(posedge clk);
            #1;
            rsv_en   = ($urandom_range(0, 1) == 1);
            rsv_addr = A'(rA);
            wr_en    = ($urandom_range(0, 9) < 4);
            wr_addr  = A'(wA);
            wr_data  = $urandom;
            for (int k = 0; k < NR; k++) begin
                rd_addr[k*A +: A] = ($urandom_range(0, 1) == 0) ? A'(rA) : A'($urandom_range(0, 15));
            end
            @(negedge clk);
            if ((cyc % 100) == 99) pulseReset();
        end

        rsv_en = 1'b0;
        wr_en  = 1'b0;
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
